// File: rtl/reg_univ.sv
// Universal WIDTH-bit register: parallel load, shift, rotate and up/down count, with serial I/O and wrap flags.
// Optional REG_UNIV_PARITY_EN adds a registered even-parity output spar.
module reg_univ #(
    parameter int               WIDTH   = 7,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             eck,
    input  logic             era,
    input  logic             ers,
    input  logic             es,
    input  logic             eena,
    input  logic [2:0]       emode,
    input  logic [WIDTH-1:0] ed,
    input  logic             esin,
    output logic [WIDTH-1:0] sq,
    output logic             sserial,
    output logic             stc,
    output logic             swrap
`ifdef REG_UNIV_PARITY_EN
    ,
    output logic             spar
`endif
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_UP   = 3'b110,
        M_DN   = 3'b111
    } mode_t;

    mode_t            mode;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             all_ones;
    logic             all_zero;

    assign mode     = mode_t'(emode);
    assign all_ones = &sq;
    assign all_zero = ~|sq;

    // Sync reset beats set, and both act regardless of the enable.
    always_comb begin
        q_nxt    = sq;
        wrap_nxt = swrap;
        if (ers) begin
            q_nxt    = RST_VAL;
            wrap_nxt = 1'b0;
        end else if (es) begin
            q_nxt = '1;
        end else if (eena) begin
            case (mode)
                M_LOAD: begin
                    q_nxt    = ed;
                    wrap_nxt = 1'b0;
                end
                M_SHL: q_nxt = {sq[WIDTH-2:0], esin};
                M_SHR: q_nxt = {esin, sq[WIDTH-1:1]};
                M_ROL: q_nxt = {sq[WIDTH-2:0], sq[WIDTH-1]};
                M_ROR: q_nxt = {sq[0], sq[WIDTH-1:1]};
                M_UP: begin
                    q_nxt = sq + WIDTH'(1);
                    if (all_ones) wrap_nxt = 1'b1;
                end
                M_DN: begin
                    q_nxt = sq - WIDTH'(1);
                    if (all_zero) wrap_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge eck or posedge era) begin
        if (era) begin
            sq    <= RST_VAL;
            swrap <= 1'b0;
        end else begin
            sq    <= q_nxt;
            swrap <= wrap_nxt;
        end
    end

    // Serial-out and terminal count look at the selected mode only, not at eena.
    always_comb begin
        sserial = 1'b0;
        stc     = 1'b0;
        case (mode)
            M_SHL, M_ROL: sserial = sq[WIDTH-1];
            M_SHR, M_ROR: sserial = sq[0];
            M_UP:         stc     = all_ones;
            M_DN:         stc     = all_zero;
            default: ;
        endcase
    end

`ifdef REG_UNIV_PARITY_EN
    // Parity is taken from the next value so it tracks sq on the same edge.
    always_ff @(posedge eck or posedge era) begin
        if (era) spar <= ^RST_VAL;
        else     spar <= ^q_nxt;
    end
`endif

endmodule
